// File: rtl/kulisch_fp16_drain.sv
// rtl/kulisch_fp16_drain.sv - resolves a 4x4 carry-save Kulisch matrix to FP16 and streams it out row-major
module kulisch_fp16_drain #(
  parameter int NUM    = 4,
  parameter int DWIDTH = 16,
  parameter int EWIDTH = 5,
  parameter int MWIDTH = 10,
  parameter int AWIDTH = 92,
  parameter int FWIDTH = 48,
  parameter int IWIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0]   C_sum_in,
  input  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0]   C_carry_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DWIDTH-1:0]                     out_data,
  output logic [IWIDTH-1:0]                     out_idx,
  output logic                                  out_last,
  output logic                                  out_ovf,
  output logic                                  out_valid,
  input  logic                                  out_ready
);
  localparam int NEL    = NUM * NUM;
  localparam int PW     = $clog2(AWIDTH);
  localparam int BIAS   = (1 << (EWIDTH - 1)) - 1;
  localparam int P_MIN  = FWIDTH - BIAS + 1;
  localparam int P_MAX  = FWIDTH + BIAS;
  localparam int SUB_SH = P_MIN - MWIDTH;
  localparam int FW     = DWIDTH - 1;

  typedef enum logic [1:0] {IDLE, ADD, NORM, OUT} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   sum_q   [NEL];
  logic [AWIDTH-1:0]   carry_q [NEL];
  logic [AWIDTH-1:0]   res_q;
  logic [IWIDTH-1:0]   idx_q, oidx_q;
  logic [DWIDTH-1:0]   data_q;
  logic                last_q, ovf_q;
  logic                accept, handshake, last_el;

  logic                sign, guard, sticky, rup, conv_ovf;
  logic [AWIDTH-1:0]   mag;
  logic [AWIDTH-2:0]   norm;
  logic [PW-1:0]       lead;
  logic [MWIDTH-1:0]   mant;
  logic [EWIDTH-1:0]   ef;
  logic [FW-1:0]       rounded;
  logic [DWIDTH-1:0]   conv_data;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign last_el   = (idx_q == IWIDTH'(NEL - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)    state_d = ADD;
      ADD:                 state_d = NORM;
      NORM:                state_d = OUT;
      OUT:  if (handshake) state_d = last_el ? IDLE : ADD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst_n;
    out_valid = (state_q == OUT);
    out_data  = data_q;
    out_idx   = oidx_q;
    out_last  = last_q;
    out_ovf   = ovf_q;
  end

  // Operand storage and resolved sum carry no reset; they are only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < NUM; r++) begin
        for (int c = 0; c < NUM; c++) begin
          sum_q[r*NUM+c]   <= C_sum_in[r][c];
          carry_q[r*NUM+c] <= C_carry_in[r][c];
        end
      end
    end
    if (state_q == ADD) res_q <= sum_q[idx_q] + carry_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx_q  <= '0;
      oidx_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) idx_q <= '0;
      else if (state_q == OUT && handshake && !last_el) idx_q <= idx_q + 1'b1;
      if (state_q == NORM) begin
        data_q <= conv_data;
        oidx_q <= idx_q;
        last_q <= last_el;
        ovf_q  <= conv_ovf;
      end
    end
  end

  // Magnitude is taken as unsigned so the most negative accumulator still converts.
  always_comb begin
    sign = res_q[AWIDTH-1];
    mag  = sign ? (~res_q + AWIDTH'(1)) : res_q;
    lead = '0;
    for (int i = 0; i < AWIDTH; i++) begin
      if (mag[i]) lead = PW'(i);
    end
    norm = (AWIDTH-1)'(mag << (PW'(AWIDTH - 1) - lead));
    if (lead >= PW'(P_MIN)) begin
      ef     = EWIDTH'(lead - PW'(P_MIN - 1));
      mant   = norm[AWIDTH-2 -: MWIDTH];
      guard  = norm[AWIDTH-2-MWIDTH];
      sticky = |norm[AWIDTH-3-MWIDTH:0];
    end else begin
      ef     = '0;
      mant   = MWIDTH'(mag >> SUB_SH);
      guard  = mag[SUB_SH-1];
      sticky = |mag[SUB_SH-2:0];
    end
    rup      = guard & (sticky | mant[0]);
    rounded  = {ef, mant} + FW'(rup);
    conv_ovf = (lead > PW'(P_MAX)) || (&rounded[FW-1:MWIDTH]);
    if (conv_ovf)             conv_data = {sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
    else if (rounded == '0)   conv_data = '0;
    else                      conv_data = {sign, rounded};
  end
endmodule

// File: tb/tb_kulisch_fp16_drain.sv
// tb/tb_kulisch_fp16_drain.sv - self-checking bench for kulisch_fp16_drain
module tb_kulisch_fp16_drain;
  localparam int N  = 4;
  localparam int AW = 92;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0][N-1:0][AW-1:0] C_sum_in, C_carry_in;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic out_last, out_ovf, out_valid;
  logic out_ready = 1'b1;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
    logic        ovf;
  } ent_t;

  ent_t exp_q[$];
  int n_checks = 0, n_err = 0, cyc = 0;
  int acc_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, ready_back_cyc = -1;
  int n_acc = 0, streams_done = 0, hs_count = 0, stall_cnt = 0;
  bit first_pending = 1'b0;
  logic [15:0] got_data[16];
  logic        got_ovf[16];
  logic [AW-1:0] ma_s[16], ma_c[16], mb_s[16], mb_c[16], mc_s[16], mc_c[16];
  logic [15:0] exp_a[16];
  logic [15:0] ovf_a;

  kulisch_fp16_drain dut (
    .clk(clk), .rst_n(rst_n), .C_sum_in(C_sum_in), .C_carry_in(C_carry_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value-level model: quantise |x| to the FP16 grid (ulp = 2^max(p-10,24) in accumulator units), RNE, encode.
  function automatic logic [16:0] model(input logic [AW-1:0] s, input logic [AW-1:0] c);
    logic [AW-1:0] r, mag, rem, half;
    int p, k, m;
    logic sg;
    logic [15:0] bits;
    r   = s + c;
    sg  = r[AW-1];
    mag = sg ? (AW'(0) - r) : r;
    if (mag == '0) return 17'h0;
    p = 0;
    while ((mag >> (p + 1)) != '0) p++;
    k    = (p - 10 > 24) ? p - 10 : 24;
    m    = int'(mag >> k);
    rem  = mag - (AW'(m) << k);
    half = AW'(1) << (k - 1);
    if (rem > half || (rem == half && (m % 2) == 1)) m++;
    if (m >= 2048) begin m = m / 2; k++; end
    if (k - 23 >= 31) return {1'b1, sg, 5'h1F, 10'h0};
    if (m < 1024) bits = 16'(m);
    else          bits = 16'(((k - 23) << 10) + (m - 1024));
    if (bits == 16'h0) return 17'h0;
    return {1'b0, sg, bits[14:0]};
  endfunction

  always @(negedge clk) begin
    logic [16:0] m;
    ent_t e, a;
    if (rst_n) begin
      exp_q.delete();
      first_pending = 1'b0;
      check({out_valid, out_data, out_idx, out_last, out_ovf, in_ready} == '0, "reset_outputs",
            {out_valid, out_data, out_idx, out_last, out_ovf, in_ready}, 0);
    end else begin
      if (in_valid && in_ready) begin
        check(exp_q.size() == 0, "accept_while_busy", exp_q.size(), 0);
        acc_cyc = cyc;
        n_acc++;
        first_pending = 1'b1;
        for (int i = 0; i < 16; i++) begin
          m = model(C_sum_in[i/4][i%4], C_carry_in[i/4][i%4]);
          e.data = m[15:0];
          e.idx  = 4'(i);
          e.last = (i == 15);
          e.ovf  = m[16];
          exp_q.push_back(e);
        end
      end
      if (out_valid) begin
        a = {out_data, out_idx, out_last, out_ovf};
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_valid", a, 0);
        end else begin
          check(a == exp_q[0], "stream", a, exp_q[0]);
          if (first_pending) begin first_valid_cyc = cyc; first_pending = 1'b0; end
          if (out_ready) begin
            got_data[out_idx] = out_data;
            got_ovf[out_idx]  = out_ovf;
            void'(exp_q.pop_front());
            hs_count++;
            if (out_last) begin last_hs_cyc = cyc; streams_done++; end
          end else if (out_idx == 4'd5) begin
            stall_cnt++;
          end
        end
      end
      if (in_ready && !out_valid && ready_back_cyc <= last_hs_cyc) ready_back_cyc = cyc;
    end
  end

  task automatic load(input int sel);
    for (int i = 0; i < 16; i++) begin
      C_sum_in[i/4][i%4]   = (sel == 0) ? ma_s[i] : (sel == 1) ? mb_s[i] : mc_s[i];
      C_carry_in[i/4][i%4] = (sel == 0) ? ma_c[i] : (sel == 1) ? mb_c[i] : mc_c[i];
    end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (streams_done < target && t < 400) begin @(negedge clk); #1; t++; end
    check(streams_done >= target, "stream_done_timeout", streams_done, target);
  endtask

  task automatic wait_idx(input int k);
    int t = 0;
    do begin @(negedge clk); #1; t++; end
    while (!(out_valid && out_idx == 4'(k)) && t < 400);
    check(out_valid && out_idx == 4'(k), "wait_idx_timeout", out_idx, k);
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (n_acc < target && t < 400) begin @(negedge clk); #1; t++; end
    check(n_acc >= target, "accept_timeout", n_acc, target);
  endtask

  initial begin
    logic [16:0] m;
    ma_s[0]  = AW'(1) << 48;               ma_c[0]  = '0;
    ma_s[1]  = AW'(1) << 48;               ma_c[1]  = AW'(1) << 48;
    ma_s[2]  = AW'(0) - (AW'(3) << 47);    ma_c[2]  = '0;
    ma_s[3]  = '0;                         ma_c[3]  = '0;
    ma_s[4]  = '1;                         ma_c[4]  = (AW'(1) << 48) + AW'(1);
    ma_s[5]  = AW'(65504) << 48;           ma_c[5]  = '0;
    ma_s[6]  = AW'(0) - (AW'(65520) << 48); ma_c[6] = '0;
    ma_s[7]  = AW'(1) << 64;               ma_c[7]  = '0;
    ma_s[8]  = AW'(1) << 24;               ma_c[8]  = '0;
    ma_s[9]  = AW'(1) << 23;               ma_c[9]  = '0;
    ma_s[10] = AW'(3) << 23;               ma_c[10] = '0;
    ma_s[11] = (AW'(1023) << 24) + (AW'(1) << 23) + AW'(1); ma_c[11] = '0;
    ma_s[12] = AW'(0) - (AW'(1) << 23);    ma_c[12] = AW'(0) - (AW'(1) << 23);
    ma_s[13] = AW'(0) - (AW'(1) << 23);    ma_c[13] = '0;
    ma_s[14] = AW'(1) << 91;               ma_c[14] = '0;
    ma_s[15] = (AW'(1) << 48) + (AW'(3) << 37); ma_c[15] = '0;
    exp_a = '{16'h3C00, 16'h4000, 16'hBE00, 16'h0000, 16'h3C00, 16'h7BFF, 16'hFC00, 16'h7C00,
              16'h0001, 16'h0000, 16'h0002, 16'h0400, 16'h8001, 16'h0000, 16'hFC00, 16'h3C02};
    ovf_a = 16'b0100_0000_1100_0000;
    for (int i = 0; i < 16; i++) begin
      mb_s[i] = AW'(i * 7919 + 13) << (3 * i + 20);
      mb_c[i] = (i % 2 == 1) ? (AW'(0) - (AW'(i + 1) << (44 + i))) : (AW'(i) << 30);
      mc_s[i] = AW'(i + 1) << 48;
      mc_c[i] = AW'(0) - (AW'(1) << 47);
    end
    load(0);

    for (int i = 0; i < 16; i++) begin
      m = model(ma_s[i], ma_c[i]);
      check(m == {ovf_a[i], exp_a[i]}, "model_pin", m, {ovf_a[i], exp_a[i]});
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "in_ready_after_reset", in_ready, 1);

    // Full-speed stream of the hand-computed matrix.
    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done(1);
    @(negedge clk); #1;
    for (int i = 0; i < 16; i++)
      check(got_data[i] == exp_a[i] && got_ovf[i] == ovf_a[i], "literal_a",
            {got_ovf[i], got_data[i]}, {ovf_a[i], exp_a[i]});
    check(first_valid_cyc - acc_cyc == 3, "first_latency", first_valid_cyc - acc_cyc, 3);
    check(last_hs_cyc - acc_cyc == 48, "last_handshake", last_hs_cyc - acc_cyc, 48);
    check(ready_back_cyc - acc_cyc == 49, "in_ready_return", ready_back_cyc - acc_cyc, 49);

    // Backpressure at idx 5 with in_valid held high across two matrices.
    load(1);
    @(posedge clk); #1 in_valid = 1'b1;
    wait_idx(4);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_idx(5);
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    check(stall_cnt == 10, "stall_cycles", stall_cnt, 10);
    wait_done(2);
    wait_acc(3);
    check(acc_cyc - last_hs_cyc == 1, "overlap_accept", acc_cyc - last_hs_cyc, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done(3);

    // Reset in the middle of a stream, held at idx 7.
    load(0);
    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idx(6);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_idx(7);
    rst_n = 1'b1;
    #1;
    check(out_valid == 1'b0, "reset_drops_valid", out_valid, 0);
    check(in_ready == 1'b0, "reset_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check(in_ready == 1'b1, "in_ready_after_midreset", in_ready, 1);

    load(2);
    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done(4);
    repeat (3) @(negedge clk);
    check(hs_count == 71, "handshake_total", hs_count, 71);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
